// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared constants, types and helpers for the maze map loader.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int MAP_ROWS = 8;
  localparam int MAP_COLS = 8;

  localparam logic [3:0] ROM_START_ADDR = 4'd8;
  localparam logic [3:0] ROM_END_ADDR   = 4'd9;
  localparam logic [3:0] ROM_LAST_ADDR  = 4'd9;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } pos_t;

  // Unpacked point byte: coordinate plus "reserved bits are zero" flag
  typedef struct packed {
    pos_t pos;
    logic ok;
  } point_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CHECK = 2'd3
  } ldr_state_t;

  // Point byte layout is {2'b00, row[2:0], col[2:0]}
  function automatic point_t unpack_point(input logic [7:0] b);
    point_t p;
    p.pos.row = b[5:3];
    p.pos.col = b[2:0];
    p.ok      = (b[7:6] == 2'b00);
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : map_loader_if
// Description : Registered-read ROM port between map_loader and maprom.
// Revision    : 1.0 - initial release
// ============================================================================
interface map_loader_if;

  logic [1:0] rom_chipsel;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;

  modport master (
    output rom_chipsel,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_chipsel,
    input  rom_addr,
    output rom_data
  );

endinterface
`default_nettype wire

// File: rtl/rom_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rom_tag_pipe
// Description : Shift register of {valid, addr} tags that tracks ROM reads
//               in flight so returning data can be steered to its register.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    adr [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        // First stage takes the tag of the address currently driven
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld[0] <= 1'b0;
            adr[0] <= '0;
          end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
          end
        end
      end else begin : g_tail
        // Later stages simply age the tag by one cycle
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld[i] <= 1'b0;
            adr[i] <= '0;
          end else begin
            vld[i] <= vld[i-1];
            adr[i] <= adr[i-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = vld[DEPTH-1];
  assign out_addr  = adr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/map_loader.sv
`default_nettype none
// ============================================================================
// Module      : map_loader
// Description : Reads one 8x8 maze map plus start/end points from maprom,
//               validates the points and serves cell queries.
// Revision    : 1.0 - initial release
// ============================================================================
module map_loader
  import maze_pkg::*;
#(
  parameter int ROM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic [1:0]         map_sel,
  map_loader_if.master       rom,
  output logic               busy,
  output logic               done,
  output logic               map_valid,
  output logic               err,
  output logic [2:0]         start_row,
  output logic [2:0]         start_col,
  output logic [2:0]         end_row,
  output logic [2:0]         end_col,
  input  logic [2:0]         q_row,
  input  logic [2:0]         q_col,
  output logic               q_open,
  output logic [63:0]        map_bits
);

  ldr_state_t state, state_n;

  logic        accept, reject, finish;
  logic [1:0]  chipsel_q;
  logic [3:0]  addr_q;
  logic [63:0] map_q;
  logic [7:0]  start_byte, end_byte;
  pos_t        start_pos, end_pos;

  logic        tag_valid;
  logic [3:0]  tag_addr;

  point_t      sp, ep;
  logic        load_good;

  // Tag follows every issued address so the returning byte lands correctly
  rom_tag_pipe #(
    .DEPTH (ROM_LATENCY),
    .AW    (4)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state == ST_ISSUE),
    .in_addr   (addr_q),
    .out_valid (tag_valid),
    .out_addr  (tag_addr)
  );

  // Point validation from the stored bytes; a point must sit on an open cell
  always_comb begin
    sp        = unpack_point(start_byte);
    ep        = unpack_point(end_byte);
    load_good = sp.ok && ep.ok
             && map_q[{sp.pos.row, sp.pos.col}]
             && map_q[{ep.pos.row, ep.pos.col}]
             && (start_byte != end_byte);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and one-cycle control strobes
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_req) begin
          if (map_sel != 2'd3) begin
            accept  = 1'b1;
            state_n = ST_ISSUE;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (addr_q == ROM_LAST_ADDR) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave on the edge that captures the end-point byte
        if (tag_valid && (tag_addr == ROM_LAST_ADDR)) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        finish  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Control outputs, ROM address sequencing and validated point outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chipsel_q <= 2'd0;
      addr_q    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      map_valid <= 1'b0;
      err       <= 1'b0;
      start_pos <= '0;
      end_pos   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        chipsel_q <= map_sel;
        addr_q    <= 4'd0;
        busy      <= 1'b1;
        map_valid <= 1'b0;
        err       <= 1'b0;
      end
      if (reject) begin
        done      <= 1'b1;
        map_valid <= 1'b0;
        err       <= 1'b1;
      end
      if ((state == ST_ISSUE) && (addr_q != ROM_LAST_ADDR)) begin
        addr_q <= addr_q + 4'd1;
      end
      if (finish) begin
        done      <= 1'b1;
        busy      <= 1'b0;
        map_valid <= load_good;
        err       <= !load_good;
        if (load_good) begin
          start_pos <= sp.pos;
          end_pos   <= ep.pos;
        end
      end
    end
  end

  // Capture returning ROM bytes into the row or point register named by the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q      <= '0;
      start_byte <= 8'd0;
      end_byte   <= 8'd0;
    end else if (tag_valid) begin
      if (tag_addr == ROM_START_ADDR)    start_byte <= rom.rom_data;
      else if (tag_addr == ROM_END_ADDR) end_byte   <= rom.rom_data;
      else if (!tag_addr[3])             map_q[{tag_addr[2:0], 3'b000} +: 8] <= rom.rom_data;
    end
  end

  assign rom.rom_chipsel = chipsel_q;
  assign rom.rom_addr    = addr_q;

  assign start_row = start_pos.row;
  assign start_col = start_pos.col;
  assign end_row   = end_pos.row;
  assign end_col   = end_pos.col;
  assign map_bits  = map_q;
  assign q_open    = map_valid & map_q[{q_row, q_col}];

endmodule
`default_nettype wire

// File: tb/tb_map_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_loader
// Description : Self-checking bench for map_loader with a maprom model and a
//               behavioural expectation model of each load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_loader;

  localparam int LAT = 2;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic [1:0] map_sel;
  logic       busy, done, map_valid, err, q_open;
  logic [2:0] start_row, start_col, end_row, end_col;
  logic [2:0] q_row, q_col;
  logic [63:0] map_bits;

  map_loader_if rom_if ();

  map_loader #(.ROM_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .map_sel   (map_sel),
    .rom       (rom_if.master),
    .busy      (busy),
    .done      (done),
    .map_valid (map_valid),
    .err       (err),
    .start_row (start_row),
    .start_col (start_col),
    .end_row   (end_row),
    .end_col   (end_col),
    .q_row     (q_row),
    .q_col     (q_col),
    .q_open    (q_open),
    .map_bits  (map_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // maprom model: inner ROM register plus output register (two edges)
  logic [7:0] rom_mem [4][16];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= rom_mem[rom_if.rom_chipsel][rom_if.rom_addr];
    rd2 <= rd1;
  end
  assign rom_if.rom_data = rd2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected state kept by the reference model
  logic        exp_valid, exp_err;
  logic [63:0] exp_bits;
  logic [1:0]  exp_cs;
  int          exp_sr, exp_sc, exp_er, exp_ec;

  task automatic model_reset();
    exp_valid = 0; exp_err = 0; exp_bits = '0; exp_cs = 0;
    exp_sr = 0; exp_sc = 0; exp_er = 0; exp_ec = 0;
  endtask

  task automatic model_load(input int sel);
    int s, e;
    bit good;
    if (sel == 3) begin
      exp_valid = 0;
      exp_err   = 1;
      return;
    end
    exp_cs = 2'(sel);
    for (int r = 0; r < 8; r++) exp_bits[8*r +: 8] = rom_mem[sel][r];
    s = int'(rom_mem[sel][8]);
    e = int'(rom_mem[sel][9]);
    good = (s < 64) && (e < 64) && (s != e);
    if (good) good = exp_bits[s] && exp_bits[e];
    exp_valid = good;
    exp_err   = !good;
    if (good) begin
      exp_sr = s / 8; exp_sc = s % 8;
      exp_er = e / 8; exp_ec = e % 8;
    end
  endtask

  task automatic start_load(input int sel);
    @(negedge clk);
    load_req = 1'b1;
    map_sel  = 2'(sel);
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // Edges after the accepting edge until done is seen (-1 on timeout)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic compare_all(input string tag);
    int r, c;
    check({tag, ".map_valid"}, 64'(map_valid), 64'(exp_valid));
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".points"}, {52'd0, start_row, start_col, end_row, end_col},
          64'((exp_sr << 9) | (exp_sc << 6) | (exp_er << 3) | exp_ec));
    check({tag, ".map_bits"}, map_bits, exp_bits);
    check({tag, ".chipsel"}, 64'(rom_if.rom_chipsel), 64'(exp_cs));
    r = $urandom_range(0, 7);
    c = $urandom_range(0, 7);
    q_row = 3'(r);
    q_col = 3'(c);
    #1;
    check({tag, ".q_open"}, 64'(q_open), 64'(exp_valid & exp_bits[8*r+c]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ctl"}, {60'd0, busy, done, map_valid, err}, 64'd0);
    check({tag, ".points"}, {52'd0, start_row, start_col, end_row, end_col}, 64'd0);
    check({tag, ".map_bits"}, map_bits, 64'd0);
    check({tag, ".rom"}, {58'd0, rom_if.rom_chipsel, rom_if.rom_addr}, 64'd0);
    check({tag, ".q_open"}, 64'(q_open), 64'd0);
  endtask

  task automatic set_map(input int sel, input logic [7:0] row_val, input logic [7:0] s, input logic [7:0] e);
    for (int r = 0; r < 8; r++) rom_mem[sel][r] = row_val;
    rom_mem[sel][8] = s;
    rom_mem[sel][9] = e;
  endtask

  initial begin
    int lat, cnt, sel, sr, sc, er, ec, mode;
    logic [7:0] sb, eb;

    for (int m = 0; m < 4; m++) for (int a = 0; a < 16; a++) rom_mem[m][a] = 8'd0;
    rst_n = 1'b0; load_req = 1'b0; map_sel = 2'd0; q_row = 3'd0; q_col = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reserved map number: immediate reject, no ROM access
    start_load(3);
    check("sel3.done", 64'(done), 64'd1);
    check("sel3.err", 64'(err), 64'd1);
    check("sel3.busy", 64'(busy), 64'd0);
    check("sel3.rom_addr", 64'(rom_if.rom_addr), 64'd0);
    model_load(3);

    // Fully open map
    set_map(0, 8'hFF, 8'h00, 8'h3F);
    start_load(0);
    wait_done(lat);
    check("map0.latency", 64'(lat), 64'(11 + LAT));
    model_load(0);
    compare_all("map0");
    q_row = 3'd3; q_col = 3'd5; #1;
    check("map0.q35", 64'(q_open), 64'd1);

    // Start on a closed cell
    set_map(1, 8'hFF, 8'h12, 8'h3F);
    rom_mem[1][2] = 8'hFB;
    start_load(1);
    wait_done(lat);
    check("map1.latency", 64'(lat), 64'(11 + LAT));
    model_load(1);
    compare_all("map1");
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      q_row = 3'(i / 8); q_col = 3'(i % 8); #1;
      if (q_open) cnt++;
    end
    check("map1.q_all_closed", 64'(cnt), 64'd0);

    // Reserved bit in end byte, then start == end
    set_map(2, 8'hFF, 8'h00, 8'h49);
    start_load(2); wait_done(lat); model_load(2);
    check("rsvd.latency", 64'(lat), 64'(11 + LAT));
    compare_all("rsvd");
    set_map(2, 8'hFF, 8'h09, 8'h09);
    start_load(2); wait_done(lat); model_load(2);
    compare_all("same");

    // Second request during a load is dropped, not queued
    start_load(0);
    repeat (4) @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("ignore.done_count", 64'(cnt), 64'd1);
    model_load(0);
    compare_all("ignore");

    // Request held high: back-to-back loads
    @(negedge clk);
    load_req = 1'b1; map_sel = 2'd1;
    rom_mem[1][8] = 8'h00;
    lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    check("held.first_done", 64'(done), 64'd1);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 60);
    load_req = 1'b0;
    check("held.gap", 64'(lat), 64'(12 + LAT));
    model_load(1);
    compare_all("held");

    // Asynchronous reset in the middle of a load
    start_load(0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("midrst.no_done", 64'(cnt), 64'd0);
    set_map(2, 8'hA5, 8'h00, 8'h3F);
    rom_mem[2][7] = 8'hFF;
    rom_mem[2][0] = 8'h01;
    start_load(2); wait_done(lat); model_load(2);
    check("after_rst.latency", 64'(lat), 64'(11 + LAT));
    compare_all("after_rst");

    // Randomized maps and points
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      if (sel != 3) begin
        for (int r = 0; r < 8; r++) rom_mem[sel][r] = 8'($urandom) | 8'($urandom);
        sr = $urandom_range(0, 7); sc = $urandom_range(0, 7);
        er = $urandom_range(0, 7); ec = $urandom_range(0, 7);
        sb = 8'(sr * 8 + sc);
        eb = 8'(er * 8 + ec);
        mode = $urandom_range(0, 7);
        if (mode == 0) sb = sb | 8'h80;
        else if (mode == 1) eb = sb;
        else if (mode >= 3) begin
          rom_mem[sel][sr] = rom_mem[sel][sr] | 8'(1 << sc);
          rom_mem[sel][er] = rom_mem[sel][er] | 8'(1 << ec);
        end
        rom_mem[sel][8] = sb;
        rom_mem[sel][9] = eb;
      end
      start_load(sel);
      wait_done(lat);
      check($sformatf("rand%0d.latency", it), 64'(lat), (sel == 3) ? 64'd0 : 64'(11 + LAT));
      model_load(sel);
      compare_all($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_loader.md
# map_loader

Sequencer that sits directly downstream of `maprom`. On request it reads one selected map (8 row bytes plus the start and end point bytes) through `maprom`'s registered read port, stores it locally and checks the start/end points. It then serves single-cycle cell queries and the start/end coordinates to the maze game logic.

## Interface

Parameters:
- `ROM_LATENCY`, default 2: edges from `rom_addr` change to valid `rom_data`. The value 2 matches the inner ROM register plus `maprom`'s output register.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `load_req`  in  1  level; sampled only in IDLE
- `map_sel`  in  2  map number; sampled with an accepted `load_req`
- `rom_chipsel`  out  2  to `maprom.chipsel`
- `rom_addr`  out  4  to `maprom.addr`
- `rom_data`  in  8  from `maprom.data`
- `busy`  out  1  high from accept until done
- `done`  out  1  one-cycle pulse at load end, including rejected loads
- `map_valid`  out  1  level; stored map checked and good
- `err`  out  1  level; last load failed, held until next accept
- `start_row`, `start_col`, `end_row`, `end_col`  out  3 each  points from the last good load
- `q_row`, `q_col`  in  3 each  query coordinate
- `q_open`  out  1  combinational: `map_valid` & cell(`q_row`,`q_col`)
- `map_bits`  out  64  row r occupies bits [8r+7:8r]

## Operation

- Cell encoding: `row[r]` bit c = 1 means open. Column 0 is bit 0.
- ROM address map:
  - addresses 0–7: rows 0–7
  - address 8: start point
  - address 9: end point
  - point byte format: {2'b00, row[2:0], col[2:0]}
- FSM states: IDLE, ISSUE, DRAIN, CHECK.
  - IDLE & `load_req` & `map_sel`≠3: latch `map_sel` into `rom_chipsel`, clear `map_valid` and `err`, set `busy`, set `rom_addr`=0, go to ISSUE.
  - IDLE & `load_req` & `map_sel`==3: no ROM access. Set `err`=1, `map_valid`=0, pulse `done`, stay IDLE. `rom_chipsel` is unchanged.
  - ISSUE: `rom_addr` increments once per cycle through 0..9. After 9 is issued, go to DRAIN.
  - DRAIN: wait until the capture for address 9 has occurred, then go to CHECK.
  - CHECK (one cycle): validate, drive `done`, clear `busy`, go to IDLE.
- Capture uses a ROM_LATENCY-deep tag pipeline (valid + 4-bit address). When a tag exits, `rom_data` is written to the row register or point register it names.
- Validation. Load fails (`err`=1, `map_valid`=0) if any of these holds:
  - start or end byte has bits[7:6]≠0
  - start cell is closed
  - end cell is closed
  - start == end
  
  Otherwise `map_valid`=1 and the point outputs update.
- `rom_chipsel` holds its value from accept until the next accepted load.
- `load_req` while `busy` is ignored. It is not queued.
- While not `map_valid`, `q_open`=0. `map_bits` shows the partially loaded contents.

## Timing

- Reset values: all outputs 0, including `rom_chipsel`, `rom_addr` and `map_bits`. FSM goes to IDLE and all tags are cleared.
- Reset asserted mid-load: immediate return to reset values. No `done` pulse.
- Accept happens at edge E0. Address k is driven after edge E0+k. Its data is captured at edge E0+k+ROM_LATENCY+1.
- `done`, `map_valid` and `err` update after edge E0+ROM_LATENCY+11. With the default latency this is E0+13. `busy` falls on the same edge.
- Rejected `map_sel`==3: `done` and `err` are visible after the accepting edge. `busy` stays 0.
- `load_req` held high continuously: a new load is accepted at the first edge after CHECK (in IDLE). The gap between `done` pulses is 12+ROM_LATENCY cycles.
- `q_open` has zero latency from `q_row`/`q_col`.

## Structure

- Shared package `maze_pkg` holds:
  - `MAP_ROWS`=8, `MAP_COLS`=8
  - `ROM_START_ADDR`=4'd8, `ROM_END_ADDR`=4'd9, `ROM_LAST_ADDR`=4'd9
  - typedef `pos_t` {row[2:0], col[2:0]}
  - function unpacking a point byte into `pos_t` plus a reserved-bits-ok flag
  - FSM state enum `ldr_state_t`
- One sub-module, `rom_tag_pipe`: parameterised-depth shift register of {valid, addr}, async-reset to all-zero.

## Test plan

- Map 0 with rows 0xFF×8, start 0x00, end 0x3F (ROM_LATENCY=2) → `done` pulse 13 edges after accept; `map_valid`=1; start=(0,0), end=(7,7); `q_open`(3,5)=1.
- Map 1 with row 2 = 0xFB and start 0x12 (row 2, col 2, which is closed) → `err`=1, `map_valid`=0, `q_open`=0 for all coordinates.
- `map_sel`=3 → `done` and `err` the next cycle; `busy` never rises; `rom_addr` stays 0.
- End byte 0x49 (reserved bit 6 set) → `err`=1. Start == end (both 0x09) → `err`=1.
- `load_req` pulsed again at E0+5 → ignored; exactly one `done`. `load_req` held high → `done` every 14 cycles.
- `rst_n` low at E0+6 → all outputs 0 asynchronously, no `done`. A subsequent load of map 2 completes correctly.
